// File: rtl/regs_wb_arbiter.sv
// Register-file writeback arbiter: dbg/ex/ls requesters share one
// buffered write port with round-robin ex/ls and bounded dbg priority.
module regs_wb_arbiter #(
    parameter int REG_ADDR_WIDTH = 16,
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic                      clk_reg,
    input  logic                      rst_reg_n,
    input  logic                      ex_valid,
    input  logic [4:0]                ex_idx,
    input  logic [REG_DATA_WIDTH-1:0] ex_data,
    output logic                      ex_ready,
    input  logic                      ls_valid,
    input  logic [4:0]                ls_idx,
    input  logic [REG_DATA_WIDTH-1:0] ls_data,
    output logic                      ls_ready,
    input  logic                      dbg_valid,
    input  logic [4:0]                dbg_idx,
    input  logic [REG_DATA_WIDTH-1:0] dbg_data,
    output logic                      dbg_ready,
    input  logic                      wb_hold,
    output logic                      reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata,
    output logic                      wb_busy,
    output logic [1:0]                wb_src
);

    localparam logic [1:0] SRC_EX  = 2'd0;
    localparam logic [1:0] SRC_LS  = 2'd1;
    localparam logic [1:0] SRC_DBG = 2'd2;

    logic                      out_valid;
    logic [4:0]                out_idx;
    logic [REG_DATA_WIDTH-1:0] out_data;
    logic [1:0]                out_src;
    logic                      rr_ls;
    logic [2:0]                dbg_cnt;
    logic [2:0]                dbg_cnt_nxt;

    logic can_accept;
    logic any_core;
    logic gnt_dbg;
    logic gnt_ex;
    logic gnt_ls;
    logic dbg_xfer;
    logic ex_xfer;
    logic ls_xfer;
    logic load;

    logic [4:0]                sel_idx;
    logic [REG_DATA_WIDTH-1:0] sel_data;
    logic [1:0]                sel_src;

    assign can_accept = ~out_valid | ~wb_hold;
    assign any_core   = ex_valid | ls_valid;

    // After four back-to-back dbg wins over waiting core traffic, yield once.
    assign gnt_dbg = dbg_valid & ~(any_core & (dbg_cnt >= 3'd4));
    assign gnt_ex  = ~gnt_dbg & ex_valid & (~ls_valid | ~rr_ls);
    assign gnt_ls  = ~gnt_dbg & ls_valid & (~ex_valid | rr_ls);

    assign dbg_ready = gnt_dbg & can_accept;
    assign ex_ready  = gnt_ex & can_accept;
    assign ls_ready  = gnt_ls & can_accept;

    assign dbg_xfer = dbg_valid & dbg_ready;
    assign ex_xfer  = ex_valid & ex_ready;
    assign ls_xfer  = ls_valid & ls_ready;

    always_comb begin
        sel_idx  = 5'd0;
        sel_data = '0;
        sel_src  = SRC_EX;
        unique case (1'b1)
            dbg_xfer: begin
                sel_idx  = dbg_idx;
                sel_data = dbg_data;
                sel_src  = SRC_DBG;
            end
            ex_xfer: begin
                sel_idx  = ex_idx;
                sel_data = ex_data;
                sel_src  = SRC_EX;
            end
            ls_xfer: begin
                sel_idx  = ls_idx;
                sel_data = ls_data;
                sel_src  = SRC_LS;
            end
            default: ;
        endcase
    end

    // Writes to x0 are accepted and dropped.
    assign load = (dbg_xfer | ex_xfer | ls_xfer) & (sel_idx != 5'd0);

    always_comb begin
        dbg_cnt_nxt = 3'd0;
        if (dbg_xfer && any_core)
            dbg_cnt_nxt = (dbg_cnt == 3'd7) ? 3'd7 : dbg_cnt + 3'd1;
    end

    always_ff @(posedge clk_reg or negedge rst_reg_n) begin
        if (!rst_reg_n) begin
            out_valid <= 1'b0;
            out_idx   <= 5'd0;
            out_data  <= '0;
            out_src   <= SRC_EX;
            rr_ls     <= 1'b0;
            dbg_cnt   <= 3'd0;
        end else begin
            dbg_cnt <= dbg_cnt_nxt;
            if (ex_xfer)
                rr_ls <= 1'b1;
            else if (ls_xfer)
                rr_ls <= 1'b0;
            if (load) begin
                out_valid <= 1'b1;
                out_idx   <= sel_idx;
                out_data  <= sel_data;
                out_src   <= sel_src;
            end else if (reg_wen) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign reg_wen   = out_valid & ~wb_hold;
    assign reg_waddr = REG_ADDR_WIDTH'({out_idx, 2'b00});
    assign reg_wdata = out_data;
    assign wb_busy   = out_valid;
    assign wb_src    = out_src;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter: vector table per cycle, with a queue of
// expected register writes filled on accept and drained on reg_wen.
module tb_regs_wb_arbiter;

    logic        clk_reg = 1'b0;
    logic        rst_reg_n = 1'b0;
    logic        ex_valid = 1'b0, ls_valid = 1'b0, dbg_valid = 1'b0;
    logic [4:0]  ex_idx = '0, ls_idx = '0, dbg_idx = '0;
    logic [31:0] ex_data = '0, ls_data = '0, dbg_data = '0;
    logic        ex_ready, ls_ready, dbg_ready;
    logic        wb_hold = 1'b0;
    logic        reg_wen;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic        wb_busy;
    logic [1:0]  wb_src;

    regs_wb_arbiter dut (
        .clk_reg(clk_reg), .rst_reg_n(rst_reg_n),
        .ex_valid(ex_valid), .ex_idx(ex_idx),
        .ex_data(ex_data), .ex_ready(ex_ready),
        .ls_valid(ls_valid), .ls_idx(ls_idx),
        .ls_data(ls_data), .ls_ready(ls_ready),
        .dbg_valid(dbg_valid), .dbg_idx(dbg_idx),
        .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .wb_hold(wb_hold), .reg_wen(reg_wen),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .wb_busy(wb_busy), .wb_src(wb_src)
    );

    always #5 clk_reg = ~clk_reg;

    typedef struct {
        logic        exv;
        logic [4:0]  exi;
        logic        lsv;
        logic [4:0]  lsi;
        logic        dbv;
        logic [4:0]  dbi;
        logic        hold;
        logic [31:0] d;
        logic [2:0]  rdy;   // {dbg, ls, ex}
        logic        wen;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [1:0]  src;
    } wr_t;

    vec_t vt[0:63];
    int   nv = 0;
    wr_t  expq[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic exv, input logic [4:0] exi,
                       input logic lsv, input logic [4:0] lsi,
                       input logic dbv, input logic [4:0] dbi,
                       input logic hold, input logic [31:0] d,
                       input logic [2:0] rdy, input logic wen,
                       input logic busy);
        vt[nv] = '{exv, exi, lsv, lsi, dbv, dbi, hold, d, rdy, wen, busy};
        nv++;
    endtask

    task automatic apply_vec(input int k);
        vec_t v;
        wr_t  w;
        v = vt[k];
        @(negedge clk_reg);
        ex_valid  = v.exv;  ex_idx  = v.exi;  ex_data  = v.d;
        ls_valid  = v.lsv;  ls_idx  = v.lsi;  ls_data  = ~v.d;
        dbg_valid = v.dbv;  dbg_idx = v.dbi;  dbg_data = v.d ^ 32'h5A5A5A5A;
        wb_hold   = v.hold;
        #1;
        chk($sformatf("v%0d ready", k),
            64'({dbg_ready, ls_ready, ex_ready}), 64'(v.rdy));
        chk($sformatf("v%0d wen", k), 64'(reg_wen), 64'(v.wen));
        chk($sformatf("v%0d busy", k), 64'(wb_busy), 64'(v.busy));
        if (reg_wen) begin
            if (expq.size() == 0) begin
                chk($sformatf("v%0d unexpected write", k), 64'(reg_waddr), 64'hFFFF_FFFF);
            end else begin
                w = expq.pop_front();
                chk($sformatf("v%0d waddr", k), 64'(reg_waddr), 64'(w.addr));
                chk($sformatf("v%0d wdata", k), 64'(reg_wdata), 64'(w.data));
                chk($sformatf("v%0d src", k), 64'(wb_src), 64'(w.src));
            end
        end
        if (v.rdy[0] && v.exi != 5'd0)
            expq.push_back('{16'({v.exi, 2'b00}), v.d, 2'd0});
        else if (v.rdy[1] && v.lsi != 5'd0)
            expq.push_back('{16'({v.lsi, 2'b00}), ~v.d, 2'd1});
        else if (v.rdy[2] && v.dbi != 5'd0)
            expq.push_back('{16'({v.dbi, 2'b00}), v.d ^ 32'h5A5A5A5A, 2'd2});
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ls_valid = 1'b0; dbg_valid = 1'b0;
        wb_hold = 1'b0;
    endtask

    int seg1;

    initial begin
        // single ex write to x5
        add(1,5, 0,0, 0,0, 0, 32'hDEADBEEF, 3'b001, 0, 0);
        add(0,0, 0,0, 0,0, 0, 32'h0,        3'b000, 1, 1);
        seg1 = nv;
        // ex/ls round robin, starting from ex after reset
        add(1,1, 1,2, 0,0, 0, 32'h11110000, 3'b001, 0, 0);
        add(1,1, 1,2, 0,0, 0, 32'h22220000, 3'b010, 1, 1);
        add(1,1, 1,2, 0,0, 0, 32'h33330000, 3'b001, 1, 1);
        add(1,1, 1,2, 0,0, 0, 32'h44440000, 3'b010, 1, 1);
        add(0,0, 0,0, 0,0, 0, 32'h0,        3'b000, 1, 1);
        // held entry blocks ls for three cycles
        add(1,3, 0,0, 0,0, 0, 32'hC0DE0003, 3'b001, 0, 0);
        add(0,0, 1,4, 0,0, 1, 32'hC0DE0004, 3'b000, 0, 1);
        add(0,0, 1,4, 0,0, 1, 32'hC0DE0004, 3'b000, 0, 1);
        add(0,0, 1,4, 0,0, 1, 32'hC0DE0004, 3'b000, 0, 1);
        add(0,0, 1,4, 0,0, 0, 32'hC0DE0004, 3'b010, 1, 1);
        add(0,0, 0,0, 0,0, 0, 32'h0,        3'b000, 1, 1);
        // dbg wins four times then yields one slot to ex
        add(1,9, 0,0, 1,8, 0, 32'hD0000001, 3'b100, 0, 0);
        add(1,9, 0,0, 1,8, 0, 32'hD0000002, 3'b100, 1, 1);
        add(1,9, 0,0, 1,8, 0, 32'hD0000003, 3'b100, 1, 1);
        add(1,9, 0,0, 1,8, 0, 32'hD0000004, 3'b100, 1, 1);
        add(1,9, 0,0, 1,8, 0, 32'hE0000005, 3'b001, 1, 1);
        add(1,9, 0,0, 1,8, 0, 32'hD0000006, 3'b100, 1, 1);
        add(0,0, 0,0, 0,0, 0, 32'h0,        3'b000, 1, 1);
        // write to x0 accepted but dropped
        add(0,0, 1,0, 0,0, 0, 32'hBAD00000, 3'b010, 0, 0);
        add(0,0, 0,0, 0,0, 0, 32'h0,        3'b000, 0, 0);
        // hold with empty stage still accepts
        add(1,10, 0,0, 0,0, 1, 32'h0A0A0A0A, 3'b001, 0, 0);
        add(0,0, 0,0, 0,0, 0, 32'h0,        3'b000, 1, 1);
        add(0,0, 0,0, 0,0, 0, 32'h0,        3'b000, 0, 0);

        #3;
        chk("rst wen", 64'(reg_wen), 64'd0);
        chk("rst waddr", 64'(reg_waddr), 64'd0);
        chk("rst wdata", 64'(reg_wdata), 64'd0);
        chk("rst busy", 64'(wb_busy), 64'd0);
        chk("rst src", 64'(wb_src), 64'd0);
        @(negedge clk_reg);
        rst_reg_n = 1'b1;

        for (int k = 0; k < seg1; k++) apply_vec(k);

        // reset while an entry is held
        @(negedge clk_reg);
        ex_valid = 1'b1; ex_idx = 5'd7; ex_data = 32'h12345678;
        #1;
        chk("hr accept", 64'(ex_ready), 64'd1);
        @(negedge clk_reg);
        ex_valid = 1'b0; wb_hold = 1'b1;
        #1;
        chk("hr held busy", 64'(wb_busy), 64'd1);
        chk("hr held wen", 64'(reg_wen), 64'd0);
        chk("hr held addr", 64'(reg_waddr), 64'h1C);
        #1;
        rst_reg_n = 1'b0;
        #1;
        chk("hr rst busy", 64'(wb_busy), 64'd0);
        chk("hr rst addr", 64'(reg_waddr), 64'd0);
        chk("hr rst data", 64'(reg_wdata), 64'd0);
        @(negedge clk_reg);
        rst_reg_n = 1'b1;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_reg);
            #1;
            chk($sformatf("hr post wen %0d", c), 64'(reg_wen), 64'd0);
        end

        for (int k = seg1; k < nv; k++) apply_vec(k);

        chk("queue drained", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regs_wb_arbiter.md
REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 The block SHALL have parameter REG_ADDR_WIDTH, default 16: byte-address width of the register-file write port.
REQ-002 The block SHALL have parameter REG_DATA_WIDTH, default 32: register data width.
REQ-003 The block SHALL have port clk_reg, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_reg_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports ex_valid (in, 1), ex_idx (in, 5), ex_data (in, REG_DATA_WIDTH) and ex_ready (out, 1), forming the execute-stage writeback requester.
REQ-006 The block SHALL have ports ls_valid (in, 1), ls_idx (in, 5), ls_data (in, REG_DATA_WIDTH) and ls_ready (out, 1), forming the load/store writeback requester.
REQ-007 The block SHALL have ports dbg_valid (in, 1), dbg_idx (in, 5), dbg_data (in, REG_DATA_WIDTH) and dbg_ready (out, 1), forming the debug write requester.
REQ-008 The block SHALL have port wb_hold, input, 1 bit: freezes the output stage while high.
REQ-009 The block SHALL have port reg_wen, output, 1 bit: register-file write enable.
REQ-010 The block SHALL have port reg_waddr, output, REG_ADDR_WIDTH bits: register-file byte address.
REQ-011 The block SHALL have port reg_wdata, output, REG_DATA_WIDTH bits: register-file write data.
REQ-012 The block SHALL have port wb_busy, output, 1 bit: output stage occupied.
REQ-013 The block SHALL have port wb_src, output, 2 bits: source of the occupied entry (0 ex, 1 ls, 2 dbg, 3 unused).

Function
REQ-014 The block SHALL hold one output entry: out_valid, idx, data, src.
REQ-015 The block SHALL compute can_accept = ~out_valid | ~wb_hold.
REQ-016 The block SHALL grant at most one requester per cycle; ready of the granted requester = can_accept; all other readys = 0.
REQ-017 A transfer SHALL occur when a requester's valid and ready are both 1.
REQ-018 The block SHALL set dbg priority above ex/ls, subject to REQ-020.
REQ-019 The block SHALL arbitrate ex vs ls by round-robin: rr pointer selects the preferred lane when both are valid; after an ex or ls transfer the pointer moves to the other lane; reset value prefers ex.
REQ-020 The block SHALL count consecutive dbg transfers made while ex_valid|ls_valid in a 3-bit saturating counter; at count 4 the next grant SHALL go to ex/ls (per rr), after which the counter clears. The counter also clears on any cycle with no dbg transfer.
REQ-021 A transfer with idx 0 SHALL be accepted (ready high) but SHALL NOT load the output entry, and SHALL NOT change out_valid beyond the drain of REQ-023.
REQ-022 A transfer with idx != 0 SHALL load the output entry at the clock edge: out_valid = 1.
REQ-023 The block SHALL drive reg_wen = out_valid & ~wb_hold, combinationally.
- When reg_wen = 1 and no new entry is loaded in the same cycle, out_valid SHALL clear at the edge.
- A simultaneous drain and load SHALL be supported: back-to-back writes at one per cycle.
REQ-024 The block SHALL drive reg_waddr = zero-extended {idx, 2'b00} and reg_wdata = stored data; both SHALL remain stable while held.
REQ-025 Latency SHALL be: transfer at edge N gives reg_wen = 1 in cycle N+1 when wb_hold = 0; while wb_hold = 1, reg_wen = 0 and the entry is retained unchanged.
REQ-026 The block SHALL drive wb_busy = out_valid and wb_src = stored src.
REQ-027 Readys SHALL depend on valids, wb_hold and internal state only, never on data or idx.

Reset
REQ-028 While rst_reg_n = 0, regardless of clock, the block SHALL force: out_valid 0, reg_wen 0, reg_waddr 0, reg_wdata 0, wb_busy 0, wb_src 0, rr pointer = ex, dbg counter 0.
REQ-029 Reset asserted mid-operation SHALL discard any held entry; no write SHALL be issued after deassertion.

Verification
REQ-030 Bench: ex_valid=1, ex_idx=5, ex_data=0xDEADBEEF, wb_hold=0 -> ex_ready=1; next cycle reg_wen=1, reg_waddr=0x0014, reg_wdata=0xDEADBEEF.
REQ-031 Bench: ex and ls both valid for 4 cycles (idx 1 and 2) -> writes alternate 0x0004, 0x0008, 0x0004, 0x0008, starting with ex after reset.
REQ-032 Bench: entry held, wb_hold=1 for 3 cycles, ls_valid=1 -> ls_ready=0 and reg_wen=0 for 3 cycles; the entry is written the cycle wb_hold falls, and ls is accepted that same cycle.
REQ-033 Bench: dbg_valid and ex_valid continuously -> 4 dbg writes, then 1 ex write, then dbg resumes.
REQ-034 Bench: ls_valid, ls_idx=0 -> ls_ready=1, no reg_wen, wb_busy stays 0.
REQ-035 Bench: rst_reg_n pulsed low while an entry is held -> outputs zero immediately; no write after release.
